// File: rtl/config_pkg.sv
// Elaborated core configuration, trimmed to the fields the configuration reader publishes.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned VLEN;
        int unsigned PLEN;
        int unsigned NrRgprPorts;
        int unsigned NrWbPorts;
        int unsigned NrIssuePorts;
        int unsigned NrCommitPorts;
        bit          RVA;
        bit          RVB;
        bit          RVC;
        bit          RVD;
        bit          RVF;
        bit          RVH;
        bit          RVS;
        bit          RVU;
        bit          RVV;
        bit          RVZCB;
        bit          RVZCMP;
        bit          RVZCMT;
        bit          RVZiCond;
        bit          RVZicntr;
        bit          RVZihpm;
        bit          ZKN;
        bit          XF16;
        bit          XF16ALT;
        bit          XF8;
        bit          XFVec;
        bit          CvxifEn;
        bit          DebugEn;
        bit          MmuPresent;
        bit          SuperscalarEn;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned ICACHE_SET_ASSOC;
        int unsigned DCACHE_LINE_WIDTH;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DataTlbEntries;
        int unsigned InstrTlbEntries;
        int unsigned BHTEntries;
        int unsigned BTBEntries;
        int unsigned NrPMPEntries;
        int unsigned RASDepth;
        logic [63:0] HaltAddress;
        logic [63:0] ExceptionAddress;
        logic [63:0] DmBaseAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cva6_cfg_reader_pkg.sv
// Word map layout of the published core configuration and the elaboration-time packer.
package cva6_cfg_reader_pkg;

    import config_pkg::*;

    localparam int unsigned NumWords = 15;
    localparam logic [31:0] CfgMagic = 32'h43564136;
    localparam logic [3:0]  LastWordIdx = 4'(NumWords - 1);

    localparam int unsigned WordMagic    = 0;
    localparam int unsigned WordXlen     = 1;
    localparam int unsigned WordVlen     = 2;
    localparam int unsigned WordPlen     = 3;
    localparam int unsigned WordPorts    = 4;
    localparam int unsigned WordExt      = 5;
    localparam int unsigned WordIcache   = 6;
    localparam int unsigned WordDcache   = 7;
    localparam int unsigned WordTlb      = 8;
    localparam int unsigned WordBp       = 9;
    localparam int unsigned WordPmpRas   = 10;
    localparam int unsigned WordHalt     = 11;
    localparam int unsigned WordExc      = 12;
    localparam int unsigned WordDmBase   = 13;
    localparam int unsigned WordChecksum = 14;

    typedef logic [31:0] cfg_word_t;
    typedef cfg_word_t [NumWords-1:0] cfg_words_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Oversized fields are truncated to their slot; the last word is the XOR of all others.
    function automatic cfg_words_t pack_cfg_words(cva6_cfg_t cfg);
        cfg_words_t w;
        w = '0;
        w[WordMagic]  = CfgMagic;
        w[WordXlen]   = cfg.XLEN;
        w[WordVlen]   = cfg.VLEN;
        w[WordPlen]   = cfg.PLEN;
        w[WordPorts]  = {8'(cfg.NrRgprPorts), 8'(cfg.NrWbPorts),
                         8'(cfg.NrIssuePorts), 8'(cfg.NrCommitPorts)};
        w[WordExt]    = {8'b0,
                         cfg.SuperscalarEn, cfg.MmuPresent, cfg.DebugEn, cfg.CvxifEn,
                         cfg.XFVec, cfg.XF8, cfg.XF16ALT, cfg.XF16,
                         cfg.ZKN, cfg.RVZihpm, cfg.RVZicntr, cfg.RVZiCond,
                         cfg.RVZCMT, cfg.RVZCMP, cfg.RVZCB, cfg.RVV,
                         cfg.RVU, cfg.RVS, cfg.RVH, cfg.RVF,
                         cfg.RVD, cfg.RVC, cfg.RVB, cfg.RVA};
        w[WordIcache] = {16'(cfg.ICACHE_LINE_WIDTH), 8'(cfg.ICACHE_INDEX_WIDTH),
                         8'(cfg.ICACHE_SET_ASSOC)};
        w[WordDcache] = {16'(cfg.DCACHE_LINE_WIDTH), 8'(cfg.DCACHE_INDEX_WIDTH),
                         8'(cfg.DCACHE_SET_ASSOC)};
        w[WordTlb]    = {16'(cfg.DataTlbEntries), 16'(cfg.InstrTlbEntries)};
        w[WordBp]     = {16'(cfg.BHTEntries), 16'(cfg.BTBEntries)};
        w[WordPmpRas] = {8'b0, 8'(cfg.NrPMPEntries), 16'(cfg.RASDepth)};
        w[WordHalt]   = cfg.HaltAddress[31:0];
        w[WordExc]    = cfg.ExceptionAddress[31:0];
        w[WordDmBase] = cfg.DmBaseAddress[31:0];
        for (int unsigned i = 0; i < WordChecksum; i++) begin
            w[WordChecksum] = w[WordChecksum] ^ w[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/cva6_cfg_reader.sv
// Serves the packed configuration map via a random-access read port and a burst stream.
module cva6_cfg_reader
    import cva6_cfg_reader_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [3:0]  addr_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        dump_i,
    input  logic        flush_i,
    output logic        s_valid_o,
    input  logic        s_ready_i,
    output logic [31:0] s_data_o,
    output logic        s_last_o,
    output logic        busy_o
);

    localparam cfg_words_t CfgRom = pack_cfg_words(CVA6Cfg);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       handshake;
    logic       rd_accept;
    logic       addr_bad;

    assign handshake = s_valid_o & s_ready_i;
    assign rd_accept = req_i & gnt_o;
    assign addr_bad  = addr_i > LastWordIdx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (dump_i) begin
                    state_d = STREAM;
                    idx_d   = 4'd0;
                end
            end
            STREAM: begin
                if ((handshake && idx_q == LastWordIdx) || flush_i) begin
                    state_d = IDLE;
                end else if (handshake) begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle drives zero on the stream data so a parked sink never sees stale map words.
    always_comb begin
        gnt_o     = 1'b0;
        s_valid_o = 1'b0;
        busy_o    = 1'b0;
        s_last_o  = 1'b0;
        s_data_o  = '0;
        if (state_q == STREAM) begin
            s_valid_o = 1'b1;
            busy_o    = 1'b1;
            s_last_o  = (idx_q == LastWordIdx);
            s_data_o  = CfgRom[idx_q];
        end else begin
            gnt_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= rd_accept;
            if (rd_accept) begin
                err_o   <= addr_bad;
                rdata_o <= addr_bad ? '0 : CfgRom[addr_i];
            end
        end
    end

endmodule

// File: tb/tb_cva6_cfg_reader.sv
// Randomized bench for cva6_cfg_reader against a word-map model derived from the reference configuration.
module tb_cva6_cfg_reader;

    localparam config_pkg::cva6_cfg_t RefCfg = '{
        XLEN: 64, VLEN: 128, PLEN: 56,
        NrRgprPorts: 2, NrWbPorts: 4, NrIssuePorts: 1, NrCommitPorts: 2,
        RVA: 1'b1, RVB: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVS: 1'b1, RVU: 1'b1,
        RVZicntr: 1'b1, DebugEn: 1'b1, MmuPresent: 1'b1,
        ICACHE_LINE_WIDTH: 128, ICACHE_INDEX_WIDTH: 12, ICACHE_SET_ASSOC: 4,
        DCACHE_LINE_WIDTH: 128, DCACHE_INDEX_WIDTH: 12, DCACHE_SET_ASSOC: 8,
        DataTlbEntries: 16, InstrTlbEntries: 16, BHTEntries: 128, BTBEntries: 32,
        NrPMPEntries: 8, RASDepth: 4,
        HaltAddress: 64'h1_0000_0800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h0,
        default: '0
    };

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic [3:0]  addr_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        dump_i;
    logic        flush_i;
    logic        s_valid_o;
    logic        s_ready_i;
    logic [31:0] s_data_o;
    logic        s_last_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_words [15];
    logic [31:0] sb_q [$];
    bit          m_stream;
    int          m_pos;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_err;

    cva6_cfg_reader #(.CVA6Cfg(RefCfg)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .dump_i(dump_i), .flush_i(flush_i),
        .s_valid_o(s_valid_o), .s_ready_i(s_ready_i), .s_data_o(s_data_o),
        .s_last_o(s_last_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Words derived straight from the field values with plain arithmetic.
    task automatic buildModel();
        bit ext [24];
        logic [31:0] sum;
        ext = '{RefCfg.RVA, RefCfg.RVB, RefCfg.RVC, RefCfg.RVD, RefCfg.RVF, RefCfg.RVH,
                RefCfg.RVS, RefCfg.RVU, RefCfg.RVV, RefCfg.RVZCB, RefCfg.RVZCMP, RefCfg.RVZCMT,
                RefCfg.RVZiCond, RefCfg.RVZicntr, RefCfg.RVZihpm, RefCfg.ZKN, RefCfg.XF16,
                RefCfg.XF16ALT, RefCfg.XF8, RefCfg.XFVec, RefCfg.CvxifEn, RefCfg.DebugEn,
                RefCfg.MmuPresent, RefCfg.SuperscalarEn};
        exp_words[0] = 32'h43564136;
        exp_words[1] = RefCfg.XLEN;
        exp_words[2] = RefCfg.VLEN;
        exp_words[3] = RefCfg.PLEN;
        exp_words[4] = (RefCfg.NrRgprPorts % 256) * 16777216 + (RefCfg.NrWbPorts % 256) * 65536
                     + (RefCfg.NrIssuePorts % 256) * 256 + (RefCfg.NrCommitPorts % 256);
        sum = 0;
        for (int i = 0; i < 24; i++) if (ext[i]) sum = sum + (32'd1 << i);
        exp_words[5] = sum;
        exp_words[6] = (RefCfg.ICACHE_LINE_WIDTH % 65536) * 65536
                     + (RefCfg.ICACHE_INDEX_WIDTH % 256) * 256 + (RefCfg.ICACHE_SET_ASSOC % 256);
        exp_words[7] = (RefCfg.DCACHE_LINE_WIDTH % 65536) * 65536
                     + (RefCfg.DCACHE_INDEX_WIDTH % 256) * 256 + (RefCfg.DCACHE_SET_ASSOC % 256);
        exp_words[8] = (RefCfg.DataTlbEntries % 65536) * 65536 + (RefCfg.InstrTlbEntries % 65536);
        exp_words[9] = (RefCfg.BHTEntries % 65536) * 65536 + (RefCfg.BTBEntries % 65536);
        exp_words[10] = (RefCfg.NrPMPEntries % 256) * 65536 + (RefCfg.RASDepth % 65536);
        exp_words[11] = 32'(RefCfg.HaltAddress % 64'h1_0000_0000);
        exp_words[12] = 32'(RefCfg.ExceptionAddress % 64'h1_0000_0000);
        exp_words[13] = 32'(RefCfg.DmBaseAddress % 64'h1_0000_0000);
        exp_words[14] = 0;
        for (int i = 0; i < 14; i++) exp_words[14] = exp_words[14] ^ exp_words[i];
    endtask

    task automatic modelReset();
        m_stream   = 1'b0;
        m_pos      = 0;
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
        exp_err    = 1'b0;
        sb_q.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rvalid"}, 32'(rvalid_o), 32'd0);
        checkOutput({tag, "_rdata"}, rdata_o, 32'd0);
        checkOutput({tag, "_err"}, 32'(err_o), 32'd0);
        checkOutput({tag, "_s_valid"}, 32'(s_valid_o), 32'd0);
        checkOutput({tag, "_s_last"}, 32'(s_last_o), 32'd0);
        checkOutput({tag, "_s_data"}, s_data_o, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    // One clock: drive inputs, log stream handshakes, advance the model, compare every output.
    task automatic applyStimulus(input logic req, input logic [3:0] addr, input logic dump,
                                 input logic flush, input logic ready);
        logic [31:0] x;
        req_i = req; addr_i = addr; dump_i = dump; flush_i = flush; s_ready_i = ready;
        if (s_valid_o && ready) begin
            sb_q.push_back(s_data_o);
            if (s_last_o) begin
                x = 0;
                foreach (sb_q[i]) x = x ^ sb_q[i];
                checkOutput("dump_len", 32'(sb_q.size()), 32'd15);
                checkOutput("dump_xor", x, 32'd0);
                sb_q.delete();
            end
        end
        if ((s_valid_o && flush) || (!s_valid_o && dump)) sb_q.delete();
        @(posedge clk_i);
        #1;
        exp_rvalid = req && !m_stream;
        if (exp_rvalid) begin
            exp_err   = (addr == 4'd15);
            exp_rdata = exp_err ? 32'd0 : exp_words[addr];
        end
        if (!m_stream) begin
            if (dump) begin
                m_stream = 1'b1;
                m_pos    = 0;
            end
        end else begin
            if (ready && m_pos == 14) m_stream = 1'b0;
            else if (ready) m_pos = m_pos + 1;
            if (flush) m_stream = 1'b0;
        end
        checkOutput("rvalid", 32'(rvalid_o), 32'(exp_rvalid));
        checkOutput("rdata", rdata_o, exp_rdata);
        if (exp_rvalid) checkOutput("err", 32'(err_o), 32'(exp_err));
        checkOutput("gnt", 32'(gnt_o), 32'(!m_stream));
        checkOutput("s_valid", 32'(s_valid_o), 32'(m_stream));
        checkOutput("busy", 32'(busy_o), 32'(m_stream));
        if (m_stream) begin
            checkOutput("s_data", s_data_o, exp_words[m_pos]);
            checkOutput("s_last", 32'(s_last_o), 32'(m_pos == 14));
        end
    endtask

    initial begin
        buildModel();
        rst_ni = 1'b0;
        req_i = 1'b1; addr_i = 4'd0; dump_i = 1'b0; flush_i = 1'b0; s_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkResetValues("reset");
        req_i = 1'b0;
        rst_ni = 1'b1;
        modelReset();

        applyStimulus(1, 4'd0, 0, 0, 0);
        checkOutput("rd_magic", rdata_o, 32'h43564136);
        applyStimulus(1, 4'd1, 0, 0, 0);
        checkOutput("rd_xlen", rdata_o, 32'd64);
        applyStimulus(1, 4'd3, 0, 0, 0);
        checkOutput("rd_plen", rdata_o, 32'd56);
        applyStimulus(1, 4'd4, 0, 0, 0);
        checkOutput("rd_word4", rdata_o, 32'h02040102);
        applyStimulus(1, 4'd11, 0, 0, 0);
        checkOutput("rd_halt_trunc", rdata_o, 32'h00000800);
        applyStimulus(1, 4'd15, 0, 0, 0);
        checkOutput("rd_oob_err", 32'(err_o), 32'd1);
        checkOutput("rd_oob_data", rdata_o, 32'd0);
        applyStimulus(0, 4'd0, 0, 0, 0);

        applyStimulus(0, 4'd0, 1, 0, 1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 4'd0, 0, 0, 1);
        checkOutput("busy_after_dump", 32'(busy_o), 32'd0);

        applyStimulus(0, 4'd0, 1, 0, 0);
        for (int i = 0; i < 32; i++)
            applyStimulus(1, 4'($urandom_range(0, 15)), 0, 0, logic'(i % 2));

        applyStimulus(0, 4'd0, 1, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 4'd0, 0, 0, 1);
        applyStimulus(0, 4'd0, 0, 1, 0);
        checkOutput("flush_s_valid", 32'(s_valid_o), 32'd0);
        applyStimulus(0, 4'd0, 1, 0, 0);
        checkOutput("restart_word0", s_data_o, 32'h43564136);
        applyStimulus(0, 4'd0, 0, 1, 0);

        applyStimulus(1, 4'd2, 1, 0, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 4'd0, 0, 0, 1);
        applyStimulus(0, 4'd0, 0, 1, 1);
        applyStimulus(0, 4'd0, 0, 1, 0);

        for (int i = 0; i < 400; i++)
            applyStimulus(logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 19) == 0),
                          logic'($urandom_range(0, 1)));
        for (int i = 0; i < 40 && m_stream; i++) applyStimulus(0, 4'd0, 0, 0, 1);

        applyStimulus(1, 4'd13, 1, 0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1, 4'd6, 0, 0, 1);
        rst_ni = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(posedge clk_i);
        #1;
        req_i = 1'b0; dump_i = 1'b0; s_ready_i = 1'b0;
        rst_ni = 1'b1;
        modelReset();
        applyStimulus(1, 4'd2, 0, 0, 0);
        checkOutput("rd_vlen_after_reset", rdata_o, 32'd128);
        applyStimulus(0, 4'd0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
